// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring, one quotient bit per clock.
// Latency: done pulses 33 clocks after start for WIDTH=32; divide-by-zero and DIV overflow take 1 clock.
// Backpressure: start is ignored while busy; a new op may issue in the done cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;     // one spare bit so the trial subtract keeps its borrow
    logic [WIDTH-1:0] quo_q;     // holds |a| at start, shifts out dividend bits, shifts in quotient bits
    logic [WIDTH-1:0] dvs_q;     // |b|
    logic             sel_rem_q; // 1: result is the remainder
    logic             neg_q_q;   // quotient must be negated
    logic             neg_r_q;   // remainder must be negated
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;

    // issue-side decode
    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] spec_res;
    // one restoring step
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] fin_res;

    // operand decode for a new request and the combinational divide step
    always_comb begin
        signed_op = ~op[0];
        a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;
        div_zero  = (b == '0);
        ovf       = (op == 2'd0) && (a == INT_MIN) && (b == '1);
        spec_res  = div_zero ? (op[1] ? a : '1) : INT_MIN;

        shifted   = {rem_q, quo_q[WIDTH-1]};
        trial     = shifted - {2'b00, dvs_q};
        if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end

        if (sel_rem_q) begin
            fin_res = neg_r_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
        end else begin
            fin_res = neg_q_q ? -quo_d : quo_d;
        end
    end

    // control FSM with registered busy/done/res
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state_q)
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= fin_res;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    done_q <= 1'b0;
                    if (start) begin
                        sel_rem_q <= op[1];
                        neg_q_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q   <= signed_op & a[WIDTH-1];
                        quo_q     <= a_abs;
                        dvs_q     <= b_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (div_zero || ovf) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            res_q   <= spec_res;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule
